// File: rtl/dpram_pkg.sv
// dpram_pkg: register offsets, command encoding and FSM state encoding shared by dpram_arbiter.
package dpram_pkg;
    localparam logic [3:0] REG_WDATA = 4'h0;
    localparam logic [3:0] REG_RDATA = 4'h2;
    localparam logic [3:0] REG_ADDR  = 4'h4;
    localparam logic [3:0] REG_CMD   = 4'h8;
    localparam logic       CMD_WRITE = 1'b1;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_DATA,
        ST_SET_ADDR,
        ST_CMD,
        ST_WAIT,
        ST_RD_STB,
        ST_RD_CAP,
        ST_DONE
    } state_t;
endpackage

// File: rtl/dpram_rr_arbiter.sv
// dpram_rr_arbiter: two-way grant logic producing a one-hot grant from req0/req1.
//   Ports: req0, req1 (requests), last (index granted last, only with DPRAM_ARB_RR_EN),
//          grant[1:0] (one-hot grant, zero when nothing requested).
//   Macro DPRAM_ARB_RR_EN: round-robin tie break; undefined gives fixed priority to port 0.
module dpram_rr_arbiter
    import dpram_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
`ifdef DPRAM_ARB_RR_EN
    input  logic       last,
`endif
    output logic [1:0] grant
);
`ifdef DPRAM_ARB_RR_EN
    // On a tie the port that was not granted last wins
    always_comb begin
        grant[0] = req0 && (!req1 || last);
        grant[1] = req1 && (!req0 || !last);
    end
`else
    always_comb begin
        grant[0] = req0;
        grant[1] = req1 && !req0;
    end
`endif
endmodule

// File: rtl/dpram_arbiter.sv
// dpram_arbiter: two-port arbiter that sequences word reads/writes into dpRAM_interface strobes.
//   Ports: clk, rst_n (sync active-low); req/we/addr/wdata per requester 0 and 1;
//          ack0/ack1 one-cycle completion, rdata read result, busy, gnt (last granted port);
//          cs/wr/rd/addr/dat_in/dp_mem_addr strobes to dpRAM_interface, dat_out from it.
//   Macro DPRAM_ARB_RR_EN: round-robin arbitration on ties; undefined gives fixed priority.
module dpram_arbiter
    import dpram_pkg::*;
#(
    parameter int DW      = 16,
    parameter int AW      = 8,
    parameter int RD_WAIT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          gnt,
    output logic          cs,
    output logic          wr,
    output logic          rd,
    output logic [3:0]    addr,
    output logic [DW-1:0] dat_in,
    output logic [AW-1:0] dp_mem_addr,
    input  logic [DW-1:0] dat_out
);
    state_t        state;
    state_t        state_nx;
    logic [1:0]    grant;
    logic          sel_we;
    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [AW-1:0] addr_hold;
    logic [DW-1:0] lat_wdata;
    logic [3:0]    cnt;
`ifdef DPRAM_ARB_RR_EN
    logic          last;
`endif

    dpram_rr_arbiter u_arb (
        .req0  (req0),
        .req1  (req1),
`ifdef DPRAM_ARB_RR_EN
        .last  (last),
`endif
        .grant (grant)
    );

    always_comb sel_we = grant[1] ? we1 : we0;

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:     state_nx = (req0 || req1) ? (sel_we ? ST_WR_DATA : ST_SET_ADDR) : ST_IDLE;
            ST_WR_DATA:  state_nx = ST_SET_ADDR;
            ST_SET_ADDR: state_nx = ST_CMD;
            ST_CMD:      state_nx = lat_we ? ST_DONE : ((RD_WAIT == 0) ? ST_RD_STB : ST_WAIT);
            ST_WAIT:     state_nx = (cnt == 4'd1) ? ST_RD_STB : ST_WAIT;
            ST_RD_STB:   state_nx = ST_RD_CAP;
            ST_RD_CAP:   state_nx = ST_DONE;
            ST_DONE:     state_nx = ST_IDLE;
            default:     state_nx = ST_IDLE;
        endcase
    end

    // Request fields are captured at grant so requester changes afterwards are ignored
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt       <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            addr_hold <= '0;
            cnt       <= 4'd0;
            rdata     <= '0;
`ifdef DPRAM_ARB_RR_EN
            last      <= 1'b1;
`endif
        end else begin
            if (state == ST_IDLE && (req0 || req1)) begin
                gnt       <= grant[1];
                lat_we    <= sel_we;
                lat_addr  <= grant[1] ? addr1 : addr0;
                lat_wdata <= grant[1] ? wdata1 : wdata0;
`ifdef DPRAM_ARB_RR_EN
                last      <= grant[1];
`endif
            end
            if (state == ST_SET_ADDR)
                addr_hold <= lat_addr;
            if (state == ST_CMD)
                cnt <= 4'(RD_WAIT);
            else if (state == ST_WAIT)
                cnt <= cnt - 4'd1;
            if (state == ST_RD_CAP)
                rdata <= dat_out;
        end
    end

    always_comb begin
        cs          = state inside {ST_WR_DATA, ST_SET_ADDR, ST_CMD, ST_RD_STB};
        wr          = state inside {ST_WR_DATA, ST_SET_ADDR, ST_CMD};
        rd          = state == ST_RD_STB;
        addr        = (state == ST_WR_DATA)  ? REG_WDATA :
                      (state == ST_SET_ADDR) ? REG_ADDR  :
                      (state == ST_CMD)      ? REG_CMD   :
                      (state == ST_RD_STB)   ? REG_RDATA : 4'h0;
        dat_in      = (state == ST_WR_DATA) ? lat_wdata :
                      (state == ST_CMD)     ? {{(DW-1){1'b0}}, lat_we == CMD_WRITE} : '0;
        // The memory address stays on the bus after SET_ADDR until the next transaction sets it
        dp_mem_addr = (state == ST_SET_ADDR) ? lat_addr : addr_hold;
        ack0        = (state == ST_DONE) && !gnt;
        ack1        = (state == ST_DONE) && gnt;
        busy        = state != ST_IDLE;
    end
endmodule

// File: doc/dpram_arbiter.md
# dpram_arbiter

Two-port arbiter and sequencer in front of `dpRAM_interface`. Two requesters (CPU bus port 0, streaming/DMA port 1) issue simple word reads and writes. The block grants one requester at a time and expands each request into the register-level strobe sequence of `dpRAM_interface`: data, address, command, and for reads a result readback. It returns data and a one-cycle acknowledge to the granted requester.

## Interface
Parameters:
- `DW`, 16, data width; matches `dpRAM_interface` `dat_in`/`dat_out`.
- `AW`, 8, dual-port memory word address width; matches `dp_mem_addr`.
- `RD_WAIT`, 2, idle cycles between command strobe and readback strobe; legal range 0..15.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req0`, `req1`  in  1  request, held until matching ack.
- `we0`, `we1`  in  1  1 = write, 0 = read; stable while req high.
- `addr0`, `addr1`  in  AW  word address; stable while req high.
- `wdata0`, `wdata1`  in  DW  write data; stable while req high.
- `ack0`, `ack1`  out  1  one-cycle completion pulse.
- `rdata`  out  DW  read result; valid in the ack cycle, held until the next read completes.
- `busy`  out  1  high from grant until the ack cycle inclusive.
- `gnt`  out  1  index of the port currently or last granted.
- `cs`, `wr`, `rd`  out  1  strobes to `dpRAM_interface`.
- `addr`  out  4  register offset to `dpRAM_interface`.
- `dat_in`  out  DW  register write data to `dpRAM_interface`.
- `dp_mem_addr`  out  AW  memory address to `dpRAM_interface`.
- `dat_out`  in  DW  register read data from `dpRAM_interface`.

## Operation
- Register map driven by this block:
  - 0x0: write data.
  - 0x4: memory address.
  - 0x8: command. `dat_in[0]` = 1 for write, 0 for read.
  - 0x2: read result.
- FSM states: IDLE, WR_DATA, SET_ADDR, CMD, WAIT, RD_STB, RD_CAP, DONE.
- IDLE: if any req is high, arbitrate, latch `gnt` and the request fields, and go to WR_DATA (write) or SET_ADDR (read).
- WR_DATA: `cs`=1, `wr`=1, `addr`=0x0, `dat_in`=wdata.
- SET_ADDR: `cs`=1, `wr`=1, `addr`=0x4, `dp_mem_addr`=addr.
- CMD: `cs`=1, `wr`=1, `addr`=0x8, `dat_in`={0, we}.
  - Write goes to DONE.
  - Read goes to WAIT, or straight to RD_STB if `RD_WAIT`=0.
- WAIT: strobes low; down-counter loaded with `RD_WAIT`; exits when it reaches 1.
- RD_STB: `cs`=1, `rd`=1, `addr`=0x2.
- RD_CAP: strobes low; `rdata` <= `dat_out`.
- DONE: ack of the granted port = 1; next state is IDLE.
- `dp_mem_addr` holds its last value outside SET_ADDR. `cs`/`wr`/`rd` are low in every state not listed above.
- A requester whose req is still high in the cycle after its ack is treated as a new request.
- Simultaneous req0 and req1 in IDLE: resolved per Configuration. A single req is always granted immediately.
- Request fields are latched at grant, so changes on a requester's inputs after grant have no effect.

## Timing
- Reset values:
  - All outputs 0, including `gnt`.
  - State IDLE; internal last-grant pointer = 1, so port 0 wins the first tie.
- Reset mid-transaction aborts at once. No ack is issued. The memory write is incomplete if the CMD state was not reached.
- Write latency: req seen in IDLE at cycle 0; WR_DATA at 1, SET_ADDR at 2, CMD at 3, ack at 4.
- Read latency: ack at cycle 5+`RD_WAIT`; with the default, cycle 7. `rdata` is valid in the ack cycle.
- Back-to-back transactions: the next grant is taken in the IDLE cycle following DONE. Minimum spacing is 5 cycles for writes and 6+`RD_WAIT` for reads.
- Every strobe to `dpRAM_interface` is exactly one cycle wide; `addr`/`dat_in` are valid in the same cycle.

## Configuration
- `DPRAM_ARB_RR_EN` defined: round-robin. On a tie, the port not granted last wins; the pointer updates on every grant.
- Not defined: fixed priority. Port 0 always wins a tie; the pointer logic is omitted. Port 1 can starve under continuous port 0 traffic, which is accepted.

## Structure
- Package `dpram_pkg`:
  - register offsets `REG_WDATA`=4'h0, `REG_RDATA`=4'h2, `REG_ADDR`=4'h4, `REG_CMD`=4'h8;
  - command bit `CMD_WRITE`=1'b1;
  - FSM state encoding.
- Sub-module `dpram_rr_arbiter`: 2-way grant logic, taking req0/req1 and the last pointer and producing a one-hot grant. It holds the macro-dependent logic.
- Top-level: FSM, request latches, wait counter, rdata register.

## Test plan
- Reset during CMD of a write: rst_n low 1 cycle -> all outputs 0 next cycle, no ack, state IDLE.
- Port 0 write 0x000B to 0x80: ack0 at cycle 4; one-cycle strobes at addr 0x0/0x4/0x8 with dat_in 0x000B/-/0x0001 and dp_mem_addr 0x80.
- Port 1 read of 0x55, `dat_out` model returns 0x00FF on 0x2: ack1 at cycle 7, rdata 0x00FF, exactly one rd strobe.
- req0 and req1 both held high with RR_EN: grants alternate 0,1,0,1. Without the macro: port 0 only while req0 is held.
- `RD_WAIT`=0 read: no WAIT cycles, ack at cycle 5.
- req0 held high through its ack: second transaction starts in the IDLE cycle after DONE, and `busy` drops for exactly that one cycle.
